lfsr_seq_ctrl: RTL and testbench

//  Sequencer for the 8-bit LFSR PRBS generator. Accepts host commands (load seed, run N words)

---
 rtl/lfsr_ctrl_pkg.sv | 21 ++
 rtl/lfsr_seq_ctrl.sv | 103 ++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared definitions for the LFSR sequencer: host op codes, FSM state encoding
// and the seed value the LFSR control port presents out of reset.
package lfsr_ctrl_pkg;

   localparam logic [7:0] LFSR_SEED_RST = 8'hAA;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_SEED = 2'b01,
      OP_RUN  = 2'b10,
      OP_RSVD = 2'b11
   } cmd_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

endpackage

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer between host config logic and an external 8-bit LFSR: loads seeds,
// runs N-word bursts and forwards LFSR words downstream with backpressure.
module lfsr_seq_ctrl
   import lfsr_ctrl_pkg::*;
#(
   parameter int NB_DATA = 8,
   parameter int NB_CNT  = 16
)
(
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   input  logic [1:0]         i_cmd_op,
   input  logic [NB_DATA-1:0] i_cmd_seed,
   input  logic [NB_CNT-1:0]  i_cmd_count,
   input  logic               i_abort,
   output logic               o_lfsr_valid,
   output logic               o_lfsr_soft_reset,
   output logic [NB_DATA-1:0] o_lfsr_seed,
   input  logic [NB_DATA-1:0] i_lfsr_data,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_data_valid,
   input  logic               i_data_ready,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output state_t             o_dbg_state
);

   state_t            state;
   logic [NB_CNT-1:0] remaining;
   logic              err_q;
   logic              cmd_fire;
   logic              xfer;
   cmd_op_t           op;

   // Valid/ready: a command or stream word moves on a posedge where valid and
   // ready are both high; valid holds its payload until that edge.
   assign op           = cmd_op_t'(i_cmd_op);
   assign o_cmd_ready  = (state == ST_IDLE);
   assign cmd_fire     = i_cmd_valid & o_cmd_ready;
   assign o_data_valid = (state == ST_RUN);
   assign xfer         = o_data_valid & i_data_ready;

   // The LFSR only steps on an accepted word, so a stalled word stays put.
   assign o_lfsr_valid      = xfer;
   assign o_lfsr_soft_reset = (state == ST_LOAD);
   assign o_data            = i_lfsr_data;
   assign o_busy            = (state != ST_IDLE);
   assign o_done            = (state == ST_DONE);
   assign o_err             = err_q;
   assign o_dbg_state       = state;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         remaining   <= '0;
         o_lfsr_seed <= NB_DATA'(LFSR_SEED_RST);
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_fire) begin
                  case (op)
                     OP_SEED: begin
                        // An all-zero seed would lock the LFSR up; reject it.
                        if (i_cmd_seed == '0) begin
                           err_q <= 1'b1;
                        end else begin
                           o_lfsr_seed <= i_cmd_seed;
                           state       <= ST_LOAD;
                        end
                     end
                     OP_RUN: begin
                        remaining <= i_cmd_count;
                        state     <= (i_cmd_count == '0) ? ST_DONE : ST_RUN;
                     end
                     OP_RSVD: err_q <= 1'b1;
                     default: ;
                  endcase
               end
            end
            ST_LOAD: state <= ST_IDLE;
            ST_RUN: begin
               if (xfer) begin
                  remaining <= remaining - NB_CNT'(1);
               end
               // Abort wins over completion; a coinciding transfer still counts.
               if (i_abort) begin
                  state <= ST_IDLE;
               end else if (xfer && (remaining == NB_CNT'(1))) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl with a behavioural 8-bit LFSR attached to its control
// port and a word-sequence reference model driven by the same polynomial.
`timescale 1ns/1ps
module tb_lfsr_seq_ctrl;
   import lfsr_ctrl_pkg::*;

   localparam int NB_DATA = 8;
   localparam int NB_CNT  = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [NB_DATA-1:0] cmd_seed;
   logic [NB_CNT-1:0]  cmd_count;
   logic               abort;
   logic               lfsr_valid;
   logic               lfsr_soft_reset;
   logic [NB_DATA-1:0] lfsr_seed;
   logic [NB_DATA-1:0] lfsr_q;
   logic [NB_DATA-1:0] data;
   logic               data_valid;
   logic               data_ready;
   logic               busy;
   logic               done;
   logic               err;
   state_t             dbg_state;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int overlap_cnt = 0;
   logic [NB_DATA-1:0] exp_q[$];
   logic [NB_DATA-1:0] got_q[$];
   logic [NB_DATA-1:0] ref_state;

   always #50 clk = ~clk;

   lfsr_seq_ctrl #(.NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) dut (
      .clk(clk), .i_rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
      .i_cmd_seed(cmd_seed), .i_cmd_count(cmd_count), .i_abort(abort),
      .o_lfsr_valid(lfsr_valid), .o_lfsr_soft_reset(lfsr_soft_reset),
      .o_lfsr_seed(lfsr_seed), .i_lfsr_data(lfsr_q),
      .o_data(data), .o_data_valid(data_valid), .i_data_ready(data_ready),
      .o_busy(busy), .o_done(done), .o_err(err), .o_dbg_state(dbg_state)
   );

   // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= 8'hAA;
      else if (lfsr_soft_reset) lfsr_q <= lfsr_seed;
      else if (lfsr_valid) lfsr_q <= lfsr_next(lfsr_q);
   end

   always @(negedge clk) if (lfsr_valid && lfsr_soft_reset) overlap_cnt++;

   // Reference: a burst of n words is the current sequence position and its successors.
   task automatic expect_words(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(ref_state);
         ref_state = lfsr_next(ref_state);
      end
   endtask

   function automatic int word_diffs(output int idx, output logic [7:0] g, output logic [7:0] e);
      int d = 0;
      idx = -1; g = '0; e = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            if (idx < 0) begin
               idx = i; e = exp_q[i];
               g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            end
            d++;
         end
      end
      return d;
   endfunction

   task automatic send_cmd(input logic [1:0] op, input logic [7:0] seed, input logic [15:0] cnt);
      cmd_valid = 1'b1; cmd_op = op; cmd_seed = seed; cmd_count = cnt;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_seed = '0; cmd_count = '0;
   endtask

   // Drives ready (rdy_pct % high) and optional abort, recording every transfer.
   task automatic run_collect(input int budget, input int rdy_pct, input int abort_at,
                              output int n_xfer, output int n_done, output int last_xfer_cyc,
                              output int done_cyc, output int stall_bad, output int lv_bad,
                              output bit timed_out, output bit first_valid);
      bit prev_stall = 0;
      bit leave;
      logic [NB_DATA-1:0] prev_data = '0;
      n_xfer = 0; n_done = 0; last_xfer_cyc = -1; done_cyc = -1;
      stall_bad = 0; lv_bad = 0; timed_out = 1; first_valid = 0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         data_ready = ($urandom_range(99, 0) < rdy_pct);
         abort = (abort_at > 0) && (n_xfer == abort_at - 1) && data_valid && data_ready;
         #1;
         if (cyc == 0) first_valid = data_valid;
         if (lfsr_valid !== (data_valid & data_ready)) lv_bad++;
         if (prev_stall && data !== prev_data) stall_bad++;
         prev_stall = data_valid && !data_ready;
         prev_data = data;
         if (data_valid && data_ready) begin
            got_q.push_back(data); n_xfer++; last_xfer_cyc = cyc;
         end
         if (done) begin n_done++; done_cyc = cyc; end
         leave = (cyc > 0) && !busy;
         @(negedge clk);
         abort = 1'b0;
         if (leave) begin timed_out = 0; break; end
      end
      abort = 1'b0;
      data_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_seed = '0; cmd_count = '0;
      abort = 1'b0; data_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_cnt++; if (lfsr_seed !== 8'hAA || done !== 1'b0 || err !== 1'b0 || lfsr_soft_reset !== 1'b0)
         $display("FAIL reset_hold: seed=%0h done=%b err=%b srst=%b required seed=aa and no pulses",
                  lfsr_seed, done, err, lfsr_soft_reset);
      else pass_cnt++;
      rst_n = 1'b1;
      #1;
      chk_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", cmd_ready); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
      chk_cnt++; if (lfsr_seed !== 8'hAA) $display("FAIL reset_seed: got %0h required aa", lfsr_seed); else pass_cnt++;
      chk_cnt++; if (data_valid !== 1'b0 || lfsr_valid !== 1'b0)
         $display("FAIL reset_stream: valid=%b lfsr_valid=%b required 0/0", data_valid, lfsr_valid);
      else pass_cnt++;
   endtask

   task automatic test_seed();
      send_cmd(2'b01, 8'hFF, '0);
      #1;
      chk_cnt++; if (lfsr_soft_reset !== 1'b1) $display("FAIL seed_srst: got %b required 1", lfsr_soft_reset); else pass_cnt++;
      chk_cnt++; if (lfsr_seed !== 8'hFF) $display("FAIL seed_reg: got %0h required ff", lfsr_seed); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1 || cmd_ready !== 1'b0)
         $display("FAIL seed_busy: busy=%b ready=%b required 1/0", busy, cmd_ready);
      else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (lfsr_soft_reset !== 1'b0) $display("FAIL seed_srst_len: got %b required 0", lfsr_soft_reset); else pass_cnt++;
      chk_cnt++; if (lfsr_q !== 8'hFF) $display("FAIL seed_loaded: lfsr got %0h required ff", lfsr_q); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL seed_idle: busy got %b required 0", busy); else pass_cnt++;
      send_cmd(2'b01, 8'h00, '0);
      #1;
      chk_cnt++; if (err !== 1'b1) $display("FAIL zero_seed_err: got %b required 1", err); else pass_cnt++;
      chk_cnt++; if (lfsr_soft_reset !== 1'b0 || busy !== 1'b0)
         $display("FAIL zero_seed_state: srst=%b busy=%b required 0/0", lfsr_soft_reset, busy);
      else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (err !== 1'b0) $display("FAIL zero_seed_pulse: got %b required 0", err); else pass_cnt++;
      chk_cnt++; if (lfsr_seed !== 8'hFF || lfsr_q !== 8'hFF)
         $display("FAIL zero_seed_keep: seed=%0h lfsr=%0h required ff/ff", lfsr_seed, lfsr_q);
      else pass_cnt++;
      ref_state = 8'hFF;
   endtask

   task automatic check_run(input string name, input int count, input int rdy_pct, input int abort_at,
                            input bit expect_done);
      int n_xfer, n_done, last_c, done_c, stall_bad, lv_bad, idx, diffs, want;
      bit timed_out, first_valid;
      logic [7:0] g, e;
      exp_q.delete(); got_q.delete();
      want = (abort_at > 0) ? abort_at : count;
      expect_words(want);
      send_cmd(2'b10, '0, 16'(count));
      run_collect(600, rdy_pct, abort_at, n_xfer, n_done, last_c, done_c, stall_bad, lv_bad,
                  timed_out, first_valid);
      chk_cnt++; if (timed_out) $display("FAIL %s_timeout: still busy after 600 cycles, required idle", name); else pass_cnt++;
      chk_cnt++; if (n_xfer !== want) $display("FAIL %s_xfers: got %0d required %0d", name, n_xfer, want); else pass_cnt++;
      diffs = word_diffs(idx, g, e);
      chk_cnt++; if (diffs !== 0)
         $display("FAIL %s_words: %0d wrong, first at %0d got %0h required %0h", name, diffs, idx, g, e);
      else pass_cnt++;
      chk_cnt++; if (n_done !== int'(expect_done))
         $display("FAIL %s_done_count: got %0d required %0d", name, n_done, int'(expect_done));
      else pass_cnt++;
      if (count > 0) begin
         chk_cnt++; if (first_valid !== 1'b1) $display("FAIL %s_latency: first valid got %b required 1", name, first_valid); else pass_cnt++;
      end
      if (expect_done && count > 0) begin
         chk_cnt++; if (done_c !== last_c + 1)
            $display("FAIL %s_done_time: got cycle %0d required %0d", name, done_c, last_c + 1);
         else pass_cnt++;
      end
      if (count == 0) begin
         chk_cnt++; if (done_c !== 0) $display("FAIL %s_done_time: got cycle %0d required 0", name, done_c); else pass_cnt++;
      end
      chk_cnt++; if (stall_bad !== 0) $display("FAIL %s_stall_stable: %0d changes, required 0", name, stall_bad); else pass_cnt++;
      chk_cnt++; if (lv_bad !== 0) $display("FAIL %s_lfsr_valid: %0d bad cycles, required 0", name, lv_bad); else pass_cnt++;
      chk_cnt++; if (lfsr_q !== ref_state) $display("FAIL %s_lfsr_pos: got %0h required %0h", name, lfsr_q, ref_state); else pass_cnt++;
   endtask

   task automatic test_run_ready();   check_run("run16", 16, 100, 0, 1'b1);  endtask
   task automatic test_run_stall();   check_run("run32", 32, 50, 0, 1'b1);   endtask
   task automatic test_abort();
      check_run("abort", 100, 100, 10, 1'b0);
      check_run("resume", 8, 100, 0, 1'b1);
   endtask
   task automatic test_run_zero();    check_run("run0", 0, 100, 0, 1'b1);    endtask

   task automatic test_bad_op();
      send_cmd(2'b11, 8'h12, 16'd5);
      #1;
      chk_cnt++; if (err !== 1'b1 || busy !== 1'b0)
         $display("FAIL op11_err: err=%b busy=%b required 1/0", err, busy);
      else pass_cnt++;
      @(negedge clk); #1;
      chk_cnt++; if (err !== 1'b0) $display("FAIL op11_pulse: got %b required 0", err); else pass_cnt++;
      send_cmd(2'b00, 8'h34, 16'd5);
      #1;
      chk_cnt++; if (busy !== 1'b0 || err !== 1'b0 || lfsr_soft_reset !== 1'b0 || lfsr_seed !== 8'hFF)
         $display("FAIL nop: busy=%b err=%b srst=%b seed=%0h required 0/0/0/ff", busy, err, lfsr_soft_reset, lfsr_seed);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] s;
      s = 8'($urandom_range(255, 1));
      abort = 1'b1;
      send_cmd(2'b01, s, '0);
      abort = 1'b0;
      #1;
      chk_cnt++; if (lfsr_soft_reset !== 1'b1 || lfsr_seed !== s)
         $display("FAIL b2b_seed: srst=%b seed=%0h required 1/%0h", lfsr_soft_reset, lfsr_seed, s);
      else pass_cnt++;
      @(negedge clk);
      ref_state = s;
      check_run("b2b_a", $urandom_range(20, 5), 70, 0, 1'b1);
      check_run("b2b_b", 4, 100, 0, 1'b1);
      chk_cnt++; if (overlap_cnt !== 0) $display("FAIL ctrl_overlap: got %0d cycles required 0", overlap_cnt); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_seed();
      test_run_ready();
      test_run_stall();
      test_abort();
      test_run_zero();
      test_bad_op();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
